// File: rtl/mmul4x4x2_seq_ctrl.sv
// Sequential 4x4 by 4x2 nibble matrix multiplier: loads 24 operand beats, computes the eight
// dot products on one shared datapath, then streams S0..S7 out. Optional macro: MMUL_PERF_CNT_EN.
module mmul4x4x2_seq_ctrl #(
    parameter int DW = 4,
    parameter int OW = 2*DW+2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [DW-1:0] in_data_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [OW-1:0] out_data_o,
    output logic [2:0]    out_idx_o,
    output logic          out_last_o,
    output logic          busy_o
`ifdef MMUL_PERF_CNT_EN
    ,
    output logic [15:0]   perf_cnt_o
`endif
);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        COMP  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [4:0]    load_cnt_q, load_cnt_d;
    logic [2:0]    k_q, k_d;
    logic [DW-1:0] op_q [24];
    logic [OW-1:0] res_q [8];
    logic          in_ready_q;
    logic          out_valid_q;
    logic [OW-1:0] out_data_q;
    logic [2:0]    out_idx_q;
    logic          out_last_q;
    logic          busy_q;
    logic [OW-1:0] dot_s;
    logic          load_we_s;
    logic          comp_we_s;

    // Shared dot product: row k>>1 of A (beats 4r..4r+3) against column k&1 of B (beats 16+2j+c).
    always_comb begin
        dot_s = '0;
        for (int j = 0; j < 4; j++) begin
            dot_s = dot_s + (OW'(op_q[{1'b0, k_q[2:1], j[1:0]}])
                           * OW'(op_q[{2'b10, j[1:0], k_q[0]}]));
        end
    end

    // Next-state and write-enable decode; clr overrides any handshake in the same cycle.
    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        k_d        = k_q;
        load_we_s  = 1'b0;
        comp_we_s  = 1'b0;
        if (clr_i) begin
            state_d    = LOAD;
            load_cnt_d = 5'd0;
            k_d        = 3'd0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (in_valid_i && in_ready_q) begin
                        load_we_s = 1'b1;
                        if (load_cnt_q == 5'd23) begin
                            state_d    = COMP;
                            load_cnt_d = 5'd0;
                            k_d        = 3'd0;
                        end else begin
                            load_cnt_d = load_cnt_q + 5'd1;
                        end
                    end else begin
                        load_cnt_d = load_cnt_q;
                    end
                end
                COMP: begin
                    comp_we_s = 1'b1;
                    if (k_q == 3'd7) begin
                        state_d = DRAIN;
                        k_d     = 3'd0;
                    end else begin
                        k_d = k_q + 3'd1;
                    end
                end
                DRAIN: begin
                    if (out_valid_q && out_ready_i) begin
                        if (k_q == 3'd7) begin
                            state_d = LOAD;
                            k_d     = 3'd0;
                        end else begin
                            k_d = k_q + 3'd1;
                        end
                    end else begin
                        k_d = k_q;
                    end
                end
                default: begin
                    state_d    = LOAD;
                    load_cnt_d = 5'd0;
                    k_d        = 3'd0;
                end
            endcase
        end
    end

    // State, operand/result storage and outputs registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOAD;
            load_cnt_q  <= 5'd0;
            k_q         <= 3'd0;
            for (int i = 0; i < 24; i++) op_q[i] <= '0;
            for (int i = 0; i < 8; i++) res_q[i] <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= 3'd0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            k_q        <= k_d;
            if (load_we_s) begin
                op_q[load_cnt_q] <= in_data_i;
            end
            if (comp_we_s) begin
                res_q[k_q] <= dot_s;
            end
            in_ready_q  <= (state_d == LOAD);
            out_valid_q <= (state_d == DRAIN);
            busy_q      <= (state_d == COMP) || (state_d == DRAIN);
            // A result written on the last COMP edge is never the one selected, so res_q is safe here.
            if (state_d == DRAIN) begin
                out_data_q <= res_q[k_d];
                out_idx_q  <= k_d;
                out_last_q <= (k_d == 3'd7);
            end else begin
                out_data_q <= '0;
                out_idx_q  <= 3'd0;
                out_last_q <= 1'b0;
            end
        end
    end

`ifdef MMUL_PERF_CNT_EN
    logic [15:0] perf_q;

    // Saturating count of busy cycles, kept across operations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= 16'd0;
        end else if (clr_i) begin
            perf_q <= 16'd0;
        end else if (busy_q && (perf_q != 16'hFFFF)) begin
            perf_q <= perf_q + 16'd1;
        end else begin
            perf_q <= perf_q;
        end
    end

    assign perf_cnt_o = perf_q;
`endif

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_idx_o   = out_idx_q;
    assign out_last_o  = out_last_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_mmul4x4x2_seq_ctrl.sv
// Self-checking bench for mmul4x4x2_seq_ctrl: vector table plus scoreboard queue, with
// hand-written clr / reset corner sequences.
module tb_mmul4x4x2_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] out_data;
    logic [2:0] out_idx;
    logic       out_last;
    logic       busy;
`ifdef MMUL_PERF_CNT_EN
    logic [15:0] perf_cnt;
`endif

    mmul4x4x2_seq_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (clr),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_idx_o   (out_idx),
        .out_last_o  (out_last),
        .busy_o      (busy)
`ifdef MMUL_PERF_CNT_EN
        ,
        .perf_cnt_o  (perf_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [15:0][3:0] a;
        logic [7:0][3:0]  b;
        logic [7:0][9:0]  exp;
        logic [7:0]       stall_pct;
    } vec_t;

    typedef struct packed {
        logic [9:0] d;
        logic [2:0] idx;
        logic       last;
    } exp_t;

    vec_t tbl [4];
    exp_t sbq [$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   acc_cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
        end
    endtask

    function automatic logic [9:0] ref_s(input logic [15:0][3:0] a, input logic [7:0][3:0] b,
                                         input int k);
        int r, c, s;
        r = k / 2;
        c = k % 2;
        s = 0;
        for (int j = 0; j < 4; j++) s += int'(a[r*4+j]) * int'(b[j*2+c]);
        return s[9:0];
    endfunction

    task automatic send_beat(input logic [3:0] d);
        int g;
        in_valid = 1'b1;
        in_data  = d;
        g = 0;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                acc_cyc = cyc;
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
            g++;
            if (g > 50) begin
                chk("beat_accept_timeout", 32'd0, 32'd1);
                break;
            end
        end
    endtask

    task automatic load_op(input logic [15:0][3:0] a, input logic [7:0][3:0] b);
        for (int n = 0; n < 16; n++) send_beat(a[n]);
        for (int n = 0; n < 8; n++) send_beat(b[n]);
        in_valid = 1'b0;
    endtask

    task automatic drain_op(input logic [7:0][9:0] expv, input int stall_pct);
        exp_t e;
        exp_t got;
        logic [9:0] prev_d;
        logic [2:0] prev_i;
        bit first, prev_stall;
        int beats, guard;
        for (int k = 0; k < 8; k++) begin
            e.d = expv[k]; e.idx = 3'(k); e.last = (k == 7);
            sbq.push_back(e);
        end
        first = 1'b1; prev_stall = 1'b0; beats = 0; guard = 0;
        prev_d = '0; prev_i = '0;
        while (beats < 8 && guard < 400) begin
            out_ready = ($urandom_range(99) >= stall_pct);
            @(negedge clk);
            if (out_valid) begin
                if (first) begin
                    chk("first_result_latency", 32'(cyc - acc_cyc), 32'd9);
                    first = 1'b0;
                end
                if (prev_stall) begin
                    chk("stall_hold_data", 32'(out_data), 32'(prev_d));
                    chk("stall_hold_idx", 32'(out_idx), 32'(prev_i));
                end
                if (out_ready) begin
                    e = sbq.pop_front();
                    got.d = out_data; got.idx = out_idx; got.last = out_last;
                    chk("result_beat", 32'(got), 32'(e));
                    beats++;
                    prev_stall = 1'b0;
                end else begin
                    prev_stall = 1'b1;
                    prev_d = out_data;
                    prev_i = out_idx;
                end
            end
            @(posedge clk); #1;
            guard++;
        end
        if (beats < 8) begin
            chk("drain_timeout_beats", 32'(beats), 32'd8);
            sbq.delete();
        end
        out_ready = 1'b0;
        @(negedge clk);
        chk("after_drain_out_valid", 32'(out_valid), 32'd0);
        chk("after_drain_in_ready", 32'(in_ready), 32'd1);
        chk("after_drain_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic wait_out_valid();
        int g;
        g = 0;
        forever begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk); #1;
            g++;
            if (g > 60) begin
                chk("wait_out_valid_timeout", 32'd0, 32'd1);
                break;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int g;
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = 4'd0; out_ready = 1'b0;

        for (int i = 0; i < 4; i++) tbl[i] = '0;
        for (int r = 0; r < 4; r++)
            for (int j = 0; j < 4; j++) tbl[0].a[r*4+j] = (r == j) ? 4'd1 : 4'd0;
        for (int n = 0; n < 8; n++) tbl[0].b[n] = 4'(n + 1);
        for (int k = 0; k < 8; k++) tbl[0].exp[k] = 10'(k + 1);
        tbl[0].stall_pct = 8'd0;
        for (int n = 0; n < 16; n++) tbl[1].a[n] = 4'd15;
        for (int n = 0; n < 8; n++) tbl[1].b[n] = 4'd15;
        for (int k = 0; k < 8; k++) tbl[1].exp[k] = 10'h384;
        tbl[1].stall_pct = 8'd30;
        for (int i = 2; i < 4; i++) begin
            for (int n = 0; n < 16; n++) tbl[i].a[n] = 4'($urandom_range(15));
            for (int n = 0; n < 8; n++) tbl[i].b[n] = 4'($urandom_range(15));
            for (int k = 0; k < 8; k++) tbl[i].exp[k] = ref_s(tbl[i].a, tbl[i].b, k);
            tbl[i].stall_pct = 8'd50;
        end

        repeat (2) @(negedge clk);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_out_data", 32'(out_data), 32'd0);
        chk("reset_out_last", 32'(out_last), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_reset_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) begin
            load_op(tbl[i].a, tbl[i].b);
            drain_op(tbl[i].exp, int'(tbl[i].stall_pct));
        end

        // clr together with beat 10 of a load: beat dropped, fresh load must line up.
        for (int n = 0; n < 10; n++) send_beat(4'($urandom_range(15)));
        clr = 1'b1; in_valid = 1'b1; in_data = 4'd9;
        @(posedge clk); #1;
        clr = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("clr_load_in_ready", 32'(in_ready), 32'd1);
        chk("clr_load_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        load_op(tbl[3].a, tbl[3].b);
        drain_op(tbl[3].exp, 0);

        // clr during COMP.
        load_op(tbl[0].a, tbl[0].b);
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("comp_busy", 32'(busy), 32'd1);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        @(negedge clk);
        chk("clr_comp_busy", 32'(busy), 32'd0);
        chk("clr_comp_in_ready", 32'(in_ready), 32'd1);
        chk("clr_comp_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;

        // clr while DRAIN presents idx 3.
        load_op(tbl[2].a, tbl[2].b);
        out_ready = 1'b1;
        g = 0;
        forever begin
            @(negedge clk);
            if (out_valid && out_idx == 3'd3) break;
            @(posedge clk); #1;
            g++;
            if (g > 60) begin
                chk("wait_idx3_timeout", 32'd0, 32'd1);
                break;
            end
        end
        chk("drain_idx3_data", 32'(out_data), 32'(tbl[2].exp[3]));
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        chk("clr_drain_out_valid", 32'(out_valid), 32'd0);
        chk("clr_drain_in_ready", 32'(in_ready), 32'd1);
        chk("clr_drain_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;

        // Asynchronous reset mid-DRAIN, then a clean operation.
        load_op(tbl[1].a, tbl[1].b);
        out_ready = 1'b0;
        wait_out_valid();
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        chk("async_rst_in_ready", 32'(in_ready), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        load_op(tbl[0].a, tbl[0].b);
        drain_op(tbl[0].exp, 0);

`ifdef MMUL_PERF_CNT_EN
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        @(negedge clk);
        chk("perf_cleared", 32'(perf_cnt), 32'd0);
        @(posedge clk); #1;
        load_op(tbl[1].a, tbl[1].b);
        drain_op(tbl[1].exp, 0);
        load_op(tbl[2].a, tbl[2].b);
        drain_op(tbl[2].exp, 0);
        @(negedge clk);
        chk("perf_two_ops", 32'(perf_cnt), 32'd32);
        @(posedge clk); #1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
